// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MMIO offsets, read-source select and lane helpers for data_mem
package dmem_pkg;
  localparam logic [1:0] MMIO_TOHOST = 2'd0;
  localparam logic [1:0] MMIO_GPIO = 2'd1;
  localparam logic [1:0] MMIO_CYCLE = 2'd2;
  typedef enum logic [1:0] {SRC_RAM, SRC_MMIO, SRC_ZERO} rd_src_t;
  function automatic logic store_misaligned(input logic [3:0] mask, input logic [1:0] off);
    return (mask == 4'b0000 || mask == 4'b0001) ? 1'b0 :
           mask == 4'b0011 ? off[0] :
           mask == 4'b1111 ? off != 2'd0 : 1'b1;
  endfunction
  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] data,
                                              input logic [3:0] mask);
    for (int i = 0; i < 4; i++)
      if (mask[i]) old[8*i +: 8] = data[8*i +: 8];
    return old;
  endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: byte-enabled single-port RAM, synchronous read-first
module dmem_ram #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [3:0]                     we,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_mem.sv
// data_mem: byte-addressed data memory with lane steering, 1-cycle reads and an MMIO window
module data_mem
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wr_data,
  output logic [31:0] d_rd_data,
  output logic        fault,
  output logic [31:0] tohost,
  output logic        tohost_valid,
  output logic [31:0] gpio_out
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [1:0] off, off_q, reg_sel;
  logic mmio_hit, ram_hit, mis, wr_ok;
  logic [3:0] mask, ram_we;
  logic [31:0] data, mmio_rd, mmio_q, ram_q, cnt, word;
  rd_src_t src_q;
  assign off = d_addr[1:0];
  assign reg_sel = d_addr[3:2];
  assign mmio_hit = d_addr[31:4] == MMIO_BASE[31:4];
  assign ram_hit = {1'b0, d_addr} < (33'(DEPTH_WORDS) << 2);
  assign mis = store_misaligned(d_we, off);
  assign wr_ok = d_we != 4'b0000 && !mis;
  assign mask = wr_ok ? d_we << off : 4'b0000;
  assign data = d_wr_data << {off, 3'b000};
  // rst gating drops a store that is in flight when reset arrives
  assign ram_we = (ram_hit && !mmio_hit && !rst) ? mask : 4'b0000;
  assign mmio_rd = reg_sel == MMIO_TOHOST ? tohost :
                   reg_sel == MMIO_GPIO   ? gpio_out :
                   reg_sel == MMIO_CYCLE  ? cnt : 32'b0;
  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .addr  (d_addr[2 +: AW]),
    .we    (ram_we),
    .wdata (data),
    .rdata (ram_q)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      off_q <= '0;
      mmio_q <= '0;
      src_q <= SRC_ZERO;
      fault <= 1'b0;
      tohost <= '0;
      tohost_valid <= 1'b0;
      gpio_out <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      off_q <= off;
      mmio_q <= mmio_rd;
      src_q <= mmio_hit ? SRC_MMIO : ram_hit ? SRC_RAM : SRC_ZERO;
      fault <= d_we != 4'b0000 && (mis || !(mmio_hit || ram_hit));
      tohost_valid <= mmio_hit && wr_ok && reg_sel == MMIO_TOHOST;
      if (mmio_hit && reg_sel == MMIO_TOHOST) tohost <= merge_lanes(tohost, data, mask);
      if (mmio_hit && reg_sel == MMIO_GPIO) gpio_out <= merge_lanes(gpio_out, data, mask);
    end
  assign word = src_q == SRC_RAM ? ram_q : src_q == SRC_MMIO ? mmio_q : 32'b0;
  assign d_rd_data = word >> {off_q, 3'b000};
endmodule
